// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/threshold flags and synchronous flush.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags.
module sync_fifo #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_acc, rd_acc;
    logic [CW-1:0]    count_nx;
    always_comb begin
        rd_acc   = rd_en & ~empty & ~clear;
        wr_acc   = wr_en & (~full | rd_acc) & ~clear;
        count_nx = clear ? '0 : count + CW'(wr_acc) - CW'(rd_acc);
    end
    always_ff @(posedge clock)
        if (wr_acc) mem[wr_ptr] <= wr_data;
    // Flags are derived from the next count so they are exact right after the edge.
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            wr_ptr       <= clear ? '0 : wr_acc ? (wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
            rd_ptr       <= clear ? '0 : rd_acc ? (rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1)) : rd_ptr;
            count        <= count_nx;
            full         <= count_nx == CW'(DEPTH);
            empty        <= count_nx == '0;
            almost_full  <= count_nx >= CW'(AFULL_THRESH);
            almost_empty <= count_nx <= CW'(AEMPTY_THRESH);
            rd_data      <= rd_acc ? mem[rd_ptr] : rd_data;
            rd_valid     <= rd_acc;
        end
`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ~clear & (overflow | (wr_en & full & ~rd_acc));
            underflow <= ~clear & (underflow | (rd_en & empty));
        end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule
